mem_burst_port: RTL and testbench
=================================

# mem_burst_port

Burst front-end for one port of the dual-port `memory` block. It accepts a command (read/write, start address, length) over a valid/ready handshake. It converts the command into a sequence of single-word memory accesses and streams write data in or read data out over valid/ready. It absorbs the memory's one-cycle read latency with a 2-entry output buffer, so back-pressure never drops data.

## Interface
- `ADDR`, 4, memory address width; addresses wrap modulo 2^ADDR
- `DATA`, 8, data word width
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command can be taken (high only in IDLE)
- `cmd_wr`  in  1  1 = write burst, 0 = read burst
- `cmd_addr`  in  ADDR  start address
- `cmd_len`  in  ADDR+1  number of words, 0..2^ADDR
- `wdata_valid` / `wdata_ready` / `wdata`  in / out / in DATA  write stream
- `rdata_valid` / `rdata_ready` / `rdata` / `rdata_last`  out / in / out DATA / out  read stream
- `mem_wr`, `mem_addr`, `mem_din`  out  1 / ADDR / DATA  memory port drive
- `mem_dout`  in  DATA  memory read data, valid one cycle after address with `mem_wr`=0
- `busy`  out  1  state != IDLE or buffer non-empty
- `done`  out  1  one-cycle pulse on burst completion

## Operation
- States: IDLE, WRITE, READ.
- IDLE:
  - `cmd_ready`=1.
  - On handshake, latch address, remaining count = `cmd_len`, direction.
  - If `cmd_len`=0, stay in IDLE and pulse `done` next cycle, with no memory access.
- WRITE:
  - `wdata_ready`=1.
  - Each cycle with `wdata_valid`: `mem_wr`=1, `mem_addr`=current address, `mem_din`=`wdata`. Then address +1 (wrap) and count -1.
  - When the count reaches 0 → IDLE.
- READ:
  - Issue a read (`mem_wr`=0, `mem_addr` advances) only when count>0 and fifo_count + inflight − pop < 2.
  - `inflight` is a 1-bit register meaning "`mem_dout` valid this cycle". Each cycle it is set, `mem_dout` is pushed into the buffer.
  - `rdata`/`rdata_valid` present the buffer head. Pop on `rdata_valid && rdata_ready`.
  - `rdata_last`=1 on the word whose pop completes the burst.
  - → IDLE after the last pop.
- `mem_addr` holds its last value when idle. `mem_wr` is 0 outside accepted write beats.
- `rdata_valid`=0 and `wdata_ready`=0 whenever not in the matching state.

## Timing
- Reset values: `cmd_ready`=1; `wdata_ready`, `rdata_valid`, `rdata_last`, `mem_wr`, `busy`, `done`=0; `mem_addr`=0. Buffer is emptied and `inflight` cleared.
- Reset mid-burst aborts immediately: no further `mem_wr`, buffered read data is discarded, and there is no `done`.
- Cycle numbering: command handshake in cycle 0.
  - The first memory access is presented in cycle 1.
  - Read data is in `mem_dout` in cycle 2, and the first `rdata_valid` is in cycle 3.
- Throughput is 1 word/cycle in both directions when the stream partner never stalls.
- `done` is registered and asserted the cycle after the final write beat or final read pop. The block is already in IDLE then, so a new command may be accepted in the same cycle `done` is high.
- Address wrap: start 4'hE with len 4 accesses E, F, 0, 1.
- `cmd_len`=2^ADDR covers every address exactly once.
- Back-pressure: with `rdata_ready`=0, at most 2 words are outstanding (buffer + inflight). Issue stalls and no word is lost or duplicated.

## Structure
- Package `mem_pkg`: state enum `burst_state_t` {IDLE, WRITE, READ} and `localparam RD_DEPTH = 2`. `memory` and this block share `ADDR`/`DATA` defaults there.
- Sub-module `rd_skid_fifo`: 2-entry synchronous FIFO with push, pop, count, head, and async active-high reset.
- Top level: FSM, address/count registers, `inflight` flag, `done` register.

## Test plan
- Write len 4 at 4'h2 (data 8'h11, 8'h22, 8'h33, 8'h44, `wdata_valid` always high) → `mem_wr` high cycles 1-4 at addresses 2-5. `done` pulses in cycle 5.
- Read back len 4 at 4'h2 with `rdata_ready`=1 → `rdata` 11, 22, 33, 44 in cycles 3-6, `rdata_last` in cycle 6, `done` in cycle 7.
- Read len 4 at 4'hE with `rdata_ready` toggling 1/0 → addresses E, F, 0, 1. Words are delivered in order and none are lost. At most 2 `mem_addr` issues occur ahead of the consumer.
- `cmd_len`=0, then a new write command in the `done` cycle → no `mem_wr` for the first command, and the second command is accepted that cycle.
- Assert `rst` during cycle 2 of a len-8 write → `mem_wr`=0 from the reset instant, `cmd_ready`=1 after release, and no `done`.
- Full read `cmd_len`=16 from 0 with random `rdata_ready` → exactly 16 words, data matches the preloaded pattern, and `rdata_last` fires only on word 16.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and sizes for the memory block and its burst front-ends.
package mem_pkg;
   localparam int MEM_ADDR = 4;
   localparam int MEM_DATA = 8;
   localparam int RD_DEPTH = 2;
   localparam int RD_CNT_W = $clog2(RD_DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } burst_state_t;
endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry FIFO that catches memory read data so consumer back-pressure never drops a word.
module rd_skid_fifo
   import mem_pkg::*;
#(
   parameter int W = MEM_DATA
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic [W-1:0]        din,
   input  logic                pop,
   output logic [W-1:0]        head,
   output logic [RD_CNT_W-1:0] count
);
   logic [W-1:0]        buf_q [RD_DEPTH];
   logic                wr_ptr_q;
   logic                rd_ptr_q;
   logic [RD_CNT_W-1:0] count_q;
   logic                do_push;
   logic                do_pop;

   assign do_pop  = pop && (count_q != '0);
   assign do_push = push && ((count_q != RD_CNT_W'(RD_DEPTH)) || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ~wr_ptr_q;
         if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
         if (do_push && !do_pop)      count_q <= count_q + 1'b1;
         else if (!do_push && do_pop) count_q <= count_q - 1'b1;
      end
   end

   // Storage carries no reset; emptiness is tracked solely by count_q.
   always_ff @(posedge clk) begin
      if (do_push) buf_q[wr_ptr_q] <= din;
   end

   assign head  = buf_q[rd_ptr_q];
   assign count = count_q;
endmodule

// File: rtl/mem_burst_port.sv
// Burst front-end: turns one (dir, addr, len) command into single-word memory accesses.
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready high
//   WRITE | one memory write per accepted wdata beat
//   READ  | issuing reads and draining the skid buffer until the last pop
module mem_burst_port
   import mem_pkg::*;
#(
   parameter int ADDR = MEM_ADDR,
   parameter int DATA = MEM_DATA
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_wr,
   input  logic [ADDR-1:0] cmd_addr,
   input  logic [ADDR:0]   cmd_len,
   input  logic            wdata_valid,
   output logic            wdata_ready,
   input  logic [DATA-1:0] wdata,
   output logic            rdata_valid,
   input  logic            rdata_ready,
   output logic [DATA-1:0] rdata,
   output logic            rdata_last,
   output logic            mem_wr,
   output logic [ADDR-1:0] mem_addr,
   output logic [DATA-1:0] mem_din,
   input  logic [DATA-1:0] mem_dout,
   output logic            busy,
   output logic            done
);
   localparam logic [ADDR:0] LEN_ONE = (ADDR + 1)'(1);

   burst_state_t        state_q, state_d;
   logic [ADDR-1:0]     addr_q;
   logic [ADDR-1:0]     last_addr_q;
   logic [ADDR:0]       cnt_q;
   logic [ADDR:0]       left_q;
   logic                inflight_q;
   logic                done_q;
   logic                cmd_hs;
   logic                wr_beat;
   logic                rd_issue;
   logic                pop;
   logic [RD_CNT_W-1:0] fifo_count;
   logic [RD_CNT_W:0]   occ;

   assign cmd_ready   = (state_q == IDLE);
   assign cmd_hs      = cmd_valid && cmd_ready;
   assign rdata_valid = (state_q == READ) && (fifo_count != '0);
   assign pop         = rdata_valid && rdata_ready;

   always_comb begin
      state_d     = state_q;
      wdata_ready = 1'b0;
      wr_beat     = 1'b0;
      rd_issue    = 1'b0;
      // Words held after this edge: buffered plus arriving, minus the one leaving.
      occ = {1'b0, fifo_count} + (RD_CNT_W + 1)'(inflight_q) - (RD_CNT_W + 1)'(pop);
      case (state_q)
         IDLE: begin
            if (cmd_hs && (cmd_len != '0)) state_d = cmd_wr ? WRITE : READ;
         end
         WRITE: begin
            wdata_ready = 1'b1;
            wr_beat     = wdata_valid;
            if (wr_beat && (cnt_q == LEN_ONE)) state_d = IDLE;
         end
         READ: begin
            rd_issue = (cnt_q != '0) && (occ < (RD_CNT_W + 1)'(RD_DEPTH));
            if (pop && (left_q == LEN_ONE)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         last_addr_q <= '0;
         cnt_q       <= '0;
         left_q      <= '0;
         inflight_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= rd_issue;
         done_q     <= 1'b0;
         if (cmd_hs) begin
            addr_q <= cmd_addr;
            cnt_q  <= cmd_len;
            left_q <= cmd_len;
            if (cmd_len == '0) done_q <= 1'b1;
         end
         if (wr_beat || rd_issue) begin
            addr_q      <= addr_q + 1'b1;
            cnt_q       <= cnt_q - 1'b1;
            last_addr_q <= addr_q;
         end
         if (pop) left_q <= left_q - 1'b1;
         if ((wr_beat && (cnt_q == LEN_ONE)) || (pop && (left_q == LEN_ONE))) done_q <= 1'b1;
      end
   end

   rd_skid_fifo #(.W(DATA)) u_rd_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight_q),
      .din   (mem_dout),
      .pop   (pop),
      .head  (rdata),
      .count (fifo_count)
   );

   assign mem_wr     = wr_beat;
   assign mem_addr   = (wr_beat || rd_issue) ? addr_q : last_addr_q;
   assign mem_din    = wdata;
   assign rdata_last = rdata_valid && (left_q == LEN_ONE);
   assign busy       = (state_q != IDLE) || (fifo_count != '0) || inflight_q;
   assign done       = done_q;
endmodule

// File: tb/tb_mem_burst_port.sv
// Directed bench for mem_burst_port with a behavioural one-cycle-latency memory model.
module tb_mem_burst_port;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
   logic [3:0] cmd_addr = '0;
   logic [4:0] cmd_len = '0;
   logic       wdata_valid = 1'b0, wdata_ready;
   logic [7:0] wdata = '0;
   logic       rdata_valid, rdata_ready = 1'b0, rdata_last;
   logic [7:0] rdata;
   logic       mem_wr;
   logic [3:0] mem_addr;
   logic [7:0] mem_din, mem_dout;
   logic       busy, done;

   logic [7:0] mem_model [16];
   logic [7:0] shadow [16];
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_wr) mem_model[mem_addr] <= mem_din;
      mem_dout <= mem_model[mem_addr];
   end

   mem_burst_port dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
      .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
      .rdata_last(rdata_last),
      .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
      .busy(busy), .done(done)
   );

   typedef struct {
      logic       cv, cw;
      logic [3:0] ca;
      logic [4:0] cl;
      logic       wv;
      logic [7:0] wd;
      logic       rr;
      logic       e_cr, e_wrdy, e_mwr, chk_a;
      logic [3:0] e_addr;
      logic       e_rv;
      logic [7:0] e_rd;
      logic       e_last, e_done, e_busy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(logic cv, logic cw, logic [3:0] ca, logic [4:0] cl,
                              logic wv, logic [7:0] wd, logic rr,
                              logic e_cr, logic e_wrdy, logic e_mwr, logic chk_a,
                              logic [3:0] e_addr, logic e_rv, logic [7:0] e_rd,
                              logic e_last, logic e_done, logic e_busy);
      vec_t r;
      r.cv = cv; r.cw = cw; r.ca = ca; r.cl = cl; r.wv = wv; r.wd = wd; r.rr = rr;
      r.e_cr = e_cr; r.e_wrdy = e_wrdy; r.e_mwr = e_mwr; r.chk_a = chk_a;
      r.e_addr = e_addr; r.e_rv = e_rv; r.e_rd = e_rd; r.e_last = e_last;
      r.e_done = e_done; r.e_busy = e_busy;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] wd_of(int kind, int i);
      logic [7:0] b;
      b = 8'(i);
      return (kind == 0) ? (8'hA0 + b) : ((b * 8'd17) ^ 8'h5C);
   endfunction

   // Write burst with wdata_valid dropping every third cycle when stall is set.
   task automatic do_write(input logic [3:0] a, input int len, input int kind, input bit stall);
      int beats = 0;
      int cyc = 0;
      logic wv;
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = a; cmd_len = 5'(len);
      @(negedge clk);
      chk("wr_cmd_ready", cmd_ready, 1'b1);
      next_cycle();
      cmd_valid = 1'b0;
      while (beats < len) begin
         wv = !(stall && (cyc % 3 == 2));
         wdata_valid = wv;
         wdata = wd_of(kind, beats);
         @(negedge clk);
         if (wv) begin
            chk("wr_mem_wr", mem_wr, 1'b1);
            chk("wr_mem_addr", mem_addr, 4'(a + 4'(beats)));
            chk("wr_mem_din", mem_din, wdata);
            shadow[4'(a + 4'(beats))] = wdata;
         end else begin
            chk("wr_stall_mem_wr", mem_wr, 1'b0);
         end
         next_cycle();
         if (wv) beats++;
         cyc++;
      end
      wdata_valid = 1'b0;
      @(negedge clk);
      chk("wr_done", done, 1'b1);
      chk("wr_done_mem_wr", mem_wr, 1'b0);
      next_cycle();
   endtask

   // Read burst; mode 0 toggles rdata_ready, mode 1 randomises it.
   task automatic do_read(input logic [3:0] a, input int len, input int mode);
      int issues = 0;
      int pops = 0;
      int cyc = 0;
      logic [3:0] exp_a;
      exp_a = a;
      rdata_ready = 1'b0;
      cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = a; cmd_len = 5'(len);
      @(negedge clk);
      chk("rd_cmd_ready", cmd_ready, 1'b1);
      next_cycle();
      cmd_valid = 1'b0;
      while (pops < len && cyc < 200) begin
         rdata_ready = (mode == 0) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         @(negedge clk);
         if (mem_wr) chk("rd_no_mem_wr", mem_wr, 1'b0);
         if (issues < len && mem_addr == exp_a) begin
            issues++;
            exp_a = exp_a + 4'd1;
         end
         if (rdata_valid && rdata_ready) begin
            chk("rd_data", rdata, shadow[4'(a + 4'(pops))]);
            chk("rd_last", rdata_last, (pops == len - 1));
            pops++;
         end
         if (issues - pops > 2) chk("rd_outstanding_le2", 32'(issues - pops), 32'd2);
         next_cycle();
         cyc++;
      end
      if (pops < len) chk("rd_timeout_pops", 32'(pops), 32'(len));
      chk("rd_issue_count", 32'(issues), 32'(len));
      rdata_ready = 1'b0;
      @(negedge clk);
      chk("rd_done", done, 1'b1);
      chk("rd_done_rvalid", rdata_valid, 1'b0);
      chk("rd_done_cmd_ready", cmd_ready, 1'b1);
      next_cycle();
   endtask

   initial begin
      // Reset values
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_wdata_ready", wdata_ready, 1'b0);
      chk("rst_rdata_valid", rdata_valid, 1'b0);
      chk("rst_rdata_last", rdata_last, 1'b0);
      chk("rst_mem_wr", mem_wr, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_mem_addr", mem_addr, 4'h0);
      next_cycle();
      rst = 1'b0;
      next_cycle();

      //         cv cw ca    cl  wv wd     rr  cr wr mw ca eaddr rv rd     lst dn bsy
      vecs.push_back(v(1, 1, 4'h2, 4, 1, 8'h11, 0,  1, 0, 0, 1, 4'h0, 0, 8'h00, 0, 0, 0));
      vecs.push_back(v(0, 0, 4'h0, 0, 1, 8'h11, 0,  0, 1, 1, 1, 4'h2, 0, 8'h00, 0, 0, 1));
      vecs.push_back(v(0, 0, 4'h0, 0, 1, 8'h22, 0,  0, 1, 1, 1, 4'h3, 0, 8'h00, 0, 0, 1));
      vecs.push_back(v(0, 0, 4'h0, 0, 1, 8'h33, 0,  0, 1, 1, 1, 4'h4, 0, 8'h00, 0, 0, 1));
      vecs.push_back(v(0, 0, 4'h0, 0, 1, 8'h44, 0,  0, 1, 1, 1, 4'h5, 0, 8'h00, 0, 0, 1));
      vecs.push_back(v(0, 0, 4'h0, 0, 0, 8'h00, 0,  1, 0, 0, 1, 4'h5, 0, 8'h00, 0, 1, 0));
      vecs.push_back(v(1, 0, 4'h2, 4, 0, 8'h00, 1,  1, 0, 0, 1, 4'h5, 0, 8'h00, 0, 0, 0));
      vecs.push_back(v(0, 0, 4'h0, 0, 0, 8'h00, 1,  0, 0, 0, 1, 4'h2, 0, 8'h00, 0, 0, 1));
      vecs.push_back(v(0, 0, 4'h0, 0, 0, 8'h00, 1,  0, 0, 0, 1, 4'h3, 0, 8'h00, 0, 0, 1));
      vecs.push_back(v(0, 0, 4'h0, 0, 0, 8'h00, 1,  0, 0, 0, 1, 4'h4, 1, 8'h11, 0, 0, 1));
      vecs.push_back(v(0, 0, 4'h0, 0, 0, 8'h00, 1,  0, 0, 0, 1, 4'h5, 1, 8'h22, 0, 0, 1));
      vecs.push_back(v(0, 0, 4'h0, 0, 0, 8'h00, 1,  0, 0, 0, 1, 4'h5, 1, 8'h33, 0, 0, 1));
      vecs.push_back(v(0, 0, 4'h0, 0, 0, 8'h00, 1,  0, 0, 0, 1, 4'h5, 1, 8'h44, 1, 0, 1));
      vecs.push_back(v(1, 1, 4'h7, 0, 0, 8'h00, 1,  1, 0, 0, 1, 4'h5, 0, 8'h00, 0, 1, 0));
      vecs.push_back(v(1, 1, 4'h8, 1, 1, 8'h5A, 1,  1, 0, 0, 1, 4'h5, 0, 8'h00, 0, 1, 0));
      vecs.push_back(v(0, 0, 4'h0, 0, 1, 8'h5A, 1,  0, 1, 1, 1, 4'h8, 0, 8'h00, 0, 0, 1));
      vecs.push_back(v(0, 0, 4'h0, 0, 0, 8'h00, 1,  1, 0, 0, 1, 4'h8, 0, 8'h00, 0, 1, 0));
      vecs.push_back(v(0, 0, 4'h0, 0, 0, 8'h00, 0,  1, 0, 0, 1, 4'h8, 0, 8'h00, 0, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         cmd_valid = vecs[i].cv; cmd_wr = vecs[i].cw; cmd_addr = vecs[i].ca;
         cmd_len = vecs[i].cl; wdata_valid = vecs[i].wv; wdata = vecs[i].wd;
         rdata_ready = vecs[i].rr;
         @(negedge clk);
         chk($sformatf("vec%0d_cmd_ready", i), cmd_ready, vecs[i].e_cr);
         chk($sformatf("vec%0d_wdata_ready", i), wdata_ready, vecs[i].e_wrdy);
         chk($sformatf("vec%0d_mem_wr", i), mem_wr, vecs[i].e_mwr);
         if (vecs[i].chk_a) chk($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
         if (vecs[i].e_mwr) chk($sformatf("vec%0d_mem_din", i), mem_din, vecs[i].wd);
         chk($sformatf("vec%0d_rdata_valid", i), rdata_valid, vecs[i].e_rv);
         if (vecs[i].e_rv) chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].e_rd);
         chk($sformatf("vec%0d_rdata_last", i), rdata_last, vecs[i].e_last);
         chk($sformatf("vec%0d_done", i), done, vecs[i].e_done);
         chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
         next_cycle();
      end
      cmd_valid = 1'b0; wdata_valid = 1'b0; rdata_ready = 1'b0;

      // Wrap-around write then read under toggling back-pressure
      do_write(4'hE, 4, 0, 1'b0);
      do_read(4'hE, 4, 0);

      // Full-memory write with stalls, then full read with random ready
      do_write(4'h0, 16, 1, 1'b1);
      do_read(4'h0, 16, 1);

      // Reset in cycle 2 of a len-8 write
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'h3; cmd_len = 5'd8;
      wdata_valid = 1'b1; wdata = 8'hC0;
      next_cycle();
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("rstw_beat1_mem_wr", mem_wr, 1'b1);
      next_cycle();
      #2 rst = 1'b1;
      #1;
      chk("rstw_mem_wr_now", mem_wr, 1'b0);
      chk("rstw_wdata_ready_now", wdata_ready, 1'b0);
      next_cycle();
      next_cycle();
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (mem_wr) chk("rstw_post_mem_wr", mem_wr, 1'b0);
         if (done) chk("rstw_post_done", done, 1'b0);
         if (c == 0) begin
            chk("rstw_cmd_ready", cmd_ready, 1'b1);
            chk("rstw_busy", busy, 1'b0);
         end
         next_cycle();
      end
      wdata_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1);
   end
endmodule
